// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryption core, one round per clock,
// round keys expanded on the fly from the captured cipher key.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   i_block / init_key valid
//   in_ready   core can accept a block (state IDLE)
//   i_block    128-bit plaintext, byte 0 in [127:120], column-major
//   init_key   KEY_BITS cipher key, first key byte in the MSBs
//   o_valid    o_block holds a finished ciphertext (state HOLD)
//   o_ready    consumer accepts o_block
//   o_block    128-bit ciphertext, retained after the handshake
//   busy       high while in ROUND or HOLD
//   dbg_state  current FSM state (0 IDLE, 1 ROUND, 2 HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds in_valid and its data until accepted; the core
// holds o_valid and o_block stable until o_ready is seen high. Neither ready
// depends combinationally on the matching valid.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        i_block,
  input  logic [KEY_BITS-1:0] init_key,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [127:0]        o_block,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, HOLD = 2'd2} state_e;

  // Entry a sits at bit offset (255-a)*8, and 255-a == ~a for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] ia;
    ia = ~a;
    return SBOX_TBL[{ia, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(b[8*i +: 8]);
    return r;
  endfunction

  // Row r of the state rotates left by r columns; byte index = row + 4*col.
  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127 - 8*(row + 4*col) -: 8] = b[127 - 8*(row + 4*((col + row) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      a0 = b[127 - 32*col -: 8];
      a1 = b[119 - 32*col -: 8];
      a2 = b[111 - 32*col -: 8];
      a3 = b[103 - 32*col -: 8];
      r[127 - 32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // 4-bit Rcon index, 1-based; indices past 10 are never used and give 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e              state_q;
  logic [3:0]          round_q;
  logic [127:0]        blk_q, blk_d, sr;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [127:0]        rk;
  logic [127:0]        o_block_q;
  logic                o_valid_q, busy_q, in_ready_q;

  generate
    if (KEY_BITS == 128) begin : g_k128
      // key_q holds K[round-1]; K[round] is derived from it in this cycle.
      always_comb begin
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon(round_q), 24'h0};
        n0 = key_q[127:96] ^ t;
        n1 = key_q[95:64]  ^ n0;
        n2 = key_q[63:32]  ^ n1;
        n3 = key_q[31:0]   ^ n2;
        rk    = {n0, n1, n2, n3};
        key_d = {n0, n1, n2, n3};
      end
    end else if (KEY_BITS == 256) begin : g_k256
      // key_q holds {K[round-1], K[round]}; K[round+1] starts at word
      // 4*(round+1), which is a multiple of 8 exactly when round is odd.
      always_comb begin
        logic [31:0] t, n0, n1, n2, n3;
        logic [3:0]  rc_idx;
        rc_idx = (round_q + 4'd1) >> 1;
        if (round_q[0]) t = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon(rc_idx), 24'h0};
        else            t = sub_word(key_q[31:0]);
        n0 = key_q[255:224] ^ t;
        n1 = key_q[223:192] ^ n0;
        n2 = key_q[191:160] ^ n1;
        n3 = key_q[159:128] ^ n2;
        rk    = key_q[127:0];
        key_d = {key_q[127:0], n0, n1, n2, n3};
      end
    end else begin : g_bad_key
      $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  // The last round skips MixColumns.
  always_comb begin
    sr    = shift_rows(sub_bytes(blk_q));
    blk_d = ((round_q == NR) ? sr : mix_columns(sr)) ^ rk;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      round_q    <= 4'd0;
      blk_q      <= '0;
      key_q      <= '0;
      o_block_q  <= '0;
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q      <= i_block ^ init_key[KEY_BITS-1 -: 128];
            key_q      <= init_key;
            round_q    <= 4'd1;
            state_q    <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          blk_q <= blk_d;
          key_q <= key_d;
          if (round_q == NR) begin
            o_block_q <= blk_d;
            o_valid_q <= 1'b1;
            round_q   <= 4'd0;
            state_q   <= HOLD;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        HOLD: begin
          if (o_ready) begin
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign o_valid   = o_valid_q;
  assign o_block   = o_block_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: one 128-bit-key and one 256-bit-key
// instance, known-answer vectors, backpressure, mid-flight reset, and
// randomised blocks with input perturbation checked against a GF(2^8)
// reference model built from first principles.
module tb_aes_iter_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         va, vb, o_ready;
  logic [127:0] i_block, key_a;
  logic [255:0] key_b;
  logic         a_in_ready, a_o_valid, a_busy, b_in_ready, b_o_valid, b_busy;
  logic [127:0] a_o_block, b_o_block;
  logic [1:0]   a_dbg, b_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbm [256];

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128)) u_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_ready(a_in_ready),
    .i_block(i_block), .init_key(key_a), .o_valid(a_o_valid), .o_ready(o_ready),
    .o_block(a_o_block), .busy(a_busy), .dbg_state(a_dbg)
  );

  aes_iter_core #(.KEY_BITS(256)) u_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_ready(b_in_ready),
    .i_block(i_block), .init_key(key_b), .o_valid(b_o_valid), .o_ready(o_ready),
    .o_block(b_o_block), .busy(b_busy), .dbg_state(b_dbg)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sbm[w[31:24]], sbm[w[23:16]], sbm[w[15:8]], sbm[w[7:0]]};
  endfunction

  // key is left-aligned; nk is 4 or 8 words.
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk,
                                           input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw_m(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbm[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- DUT views ----------------
  function automatic logic ov(input bit w);  return w ? b_o_valid  : a_o_valid;  endfunction
  function automatic logic ir(input bit w);  return w ? b_in_ready : a_in_ready; endfunction
  function automatic logic bz(input bit w);  return w ? b_busy     : a_busy;     endfunction
  function automatic logic [127:0] ob(input bit w); return w ? b_o_block : a_o_block; endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit w, input logic [255:0] key, input logic [127:0] pt,
                      output int waited);
    waited = 0;
    while (!ir(w) && waited < 50) begin
      step();
      waited++;
    end
    chk("send_ready", 128'(ir(w)), 128'(1));
    i_block = pt;
    key_a   = key[255:128];
    key_b   = key;
    if (w) vb = 1'b1; else va = 1'b1;
    step();
    va = 1'b0;
    vb = 1'b0;
  endtask

  // Counts edges after the accept edge until o_valid; optionally scrambles
  // inputs, the instance's in_valid and o_ready while rounds are running.
  task automatic wait_out(input bit w, input bit perturb, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
      if (perturb && !ov(w)) begin
        i_block = rnd128();
        key_a   = rnd128();
        key_b   = {rnd128(), rnd128()};
        if (w) vb = 1'($urandom_range(0, 1)); else va = 1'($urandom_range(0, 1));
        o_ready = 1'($urandom_range(0, 1));
      end
    end while (!ov(w) && lat < 40);
    va = 1'b0;
    vb = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int lat, wt;
    logic [255:0] rk;
    logic [127:0] rp, ex;

    reset = 1'b0; va = 1'b0; vb = 1'b0; o_ready = 1'b0;
    i_block = '0; key_a = '0; key_b = '0;
    for (int i = 0; i < 256; i++) sbm[i] = sbox_calc(8'(i));

    // Reset state
    step();
    chk("rst_a_ovalid", 128'(a_o_valid), 128'(0));
    chk("rst_a_busy",   128'(a_busy),    128'(0));
    chk("rst_a_oblock", a_o_block,       128'(0));
    chk("rst_a_state",  128'(a_dbg),     128'(0));
    chk("rst_b_ovalid", 128'(b_o_valid), 128'(0));
    chk("rst_b_oblock", b_o_block,       128'(0));
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rel_a_inready", 128'(a_in_ready), 128'(1));
    chk("rel_b_inready", 128'(b_in_ready), 128'(1));

    // FIPS-197 appendix B vector, o_ready held high
    o_ready = 1'b1;
    send(0, {KEY1, 128'h0}, PT1, wt);
    chk("kat1_busy_round", 128'(a_busy), 128'(1));
    wait_out(0, 0, lat);
    chk("kat1_latency", 128'(lat), 128'(10));
    chk("kat1_block",   a_o_block, CT1);
    chk("kat1_inready", 128'(a_in_ready), 128'(0));
    step();
    chk("kat1_ovalid_fall", 128'(a_o_valid), 128'(0));
    chk("kat1_retain",      a_o_block, CT1);
    chk("kat1_idle_busy",   128'(a_busy), 128'(0));

    // FIPS-197 appendix C.1
    send(0, {KEY2, 128'h0}, PT2, wt);
    wait_out(0, 0, lat);
    chk("kat2_latency", 128'(lat), 128'(10));
    chk("kat2_block",   a_o_block, CT2);
    step();

    // FIPS-197 appendix C.3 on the 256-bit instance
    send(1, KEY3, PT2, wt);
    wait_out(1, 0, lat);
    chk("kat3_latency", 128'(lat), 128'(14));
    chk("kat3_block",   b_o_block, CT3);
    step();
    chk("kat3_ovalid_fall", 128'(b_o_valid), 128'(0));

    // Backpressure: result held 20 cycles while a second block waits
    o_ready = 1'b0;
    send(0, {KEY2, 128'h0}, PT2, wt);
    wait_out(0, 0, lat);
    chk("bp_latency", 128'(lat), 128'(10));
    i_block = PT1;
    key_a   = KEY1;
    va      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_ovalid",  128'(a_o_valid),  128'(1));
      chk("bp_block",   a_o_block,        CT2);
      chk("bp_inready", 128'(a_in_ready), 128'(0));
      chk("bp_busy",    128'(a_busy),     128'(1));
    end
    o_ready = 1'b1;
    step();
    chk("bp_hs_ovalid",  128'(a_o_valid),  128'(0));
    chk("bp_hs_inready", 128'(a_in_ready), 128'(1));
    chk("bp_hs_retain",  a_o_block,        CT2);
    step();
    va = 1'b0;
    chk("bp_second_accepted", 128'(a_in_ready), 128'(0));
    wait_out(0, 0, lat);
    chk("bp_second_latency", 128'(lat), 128'(10));
    chk("bp_second_block",   a_o_block, CT1);
    step();

    // Reset during round 5
    send(0, {KEY2, 128'h0}, PT2, wt);
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy_before", 128'(a_busy), 128'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_oblock", a_o_block,      128'(0));
    chk("mid_rst_ovalid", 128'(a_o_valid), 128'(0));
    chk("mid_rst_busy",   128'(a_busy),    128'(0));
    chk("mid_rst_state",  128'(a_dbg),     128'(0));
    @(negedge clk);
    reset = 1'b1;
    step();
    send(0, {KEY1, 128'h0}, PT1, wt);
    wait_out(0, 0, lat);
    chk("mid_after_latency", 128'(lat), 128'(10));
    chk("mid_after_block",   a_o_block, CT1);
    o_ready = 1'b1;
    step();

    // Back-to-back random blocks with perturbed inputs, 128-bit key
    for (int n = 0; n < 100; n++) begin
      rk = {rnd128(), 128'h0};
      rp = rnd128();
      ex = aes_ref(rk, 4, rp);
      send(0, rk, rp, wt);
      chk("r128_b2b_wait", 128'(wt), 128'(0));
      wait_out(0, 1, lat);
      chk("r128_latency", 128'(lat), 128'(10));
      chk("r128_block",   a_o_block, ex);
      o_ready = 1'b1;
      step();
      chk("r128_ovalid_fall", 128'(a_o_valid), 128'(0));
    end

    // Random blocks with perturbed inputs, 256-bit key
    for (int n = 0; n < 20; n++) begin
      rk = {rnd128(), rnd128()};
      rp = rnd128();
      ex = aes_ref(rk, 8, rp);
      send(1, rk, rp, wt);
      chk("r256_b2b_wait", 128'(wt), 128'(0));
      wait_out(1, 1, lat);
      chk("r256_latency", 128'(lat), 128'(14));
      chk("r256_block",   b_o_block, ex);
      chk("r256_busy",    128'(bz(1)), 128'(1));
      o_ready = 1'b1;
      step();
      chk("r256_ovalid_fall", 128'(ov(1)), 128'(0));
      chk("r256_retain",      ob(1), ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative AES encryption core that computes one round per clock, parametrised for 128-bit or 256-bit keys.
- Generates round keys on the fly from the captured cipher key.
- Uses valid/ready handshakes on both input and output, with output backpressure; the result is held until the consumer accepts it.
- Sits between a block source (plaintext plus key) and a downstream consumer. It is the next generation of the single-key, no-handshake AES-128 core.

Parameters:
- KEY_BITS, 128: cipher key length. Legal values are 128 and 256; any other value is an elaboration error.
- NR, derived (10 when KEY_BITS=128, 14 when KEY_BITS=256): number of rounds. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  i_block and init_key are valid.
- in_ready  out  1  core can accept a block.
- i_block  in  128  plaintext; byte 0 is [127:120], column-major as in FIPS-197.
- init_key  in  KEY_BITS  cipher key; first key byte is the MSB.
- o_valid  out  1  o_block holds a finished ciphertext.
- o_ready  in  1  consumer accepts o_block.
- o_block  out  128  ciphertext.
- busy  out  1  high while in ROUND or HOLD.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, round counter=0, state/key registers=0, o_block=0, o_valid=0, busy=0.
  - in_ready=1 once reset is released.
  - Reset asserted mid-operation aborts the block; no partial output is ever presented.
- FSM states: IDLE, ROUND, HOLD.
  - in_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - o_valid = (state==HOLD).
- IDLE: on a clock edge with in_valid & in_ready (accept edge E0):
  - state_reg <= i_block ^ init_key[KEY_BITS-1 -: 128] (initial AddRoundKey).
  - The full init_key is captured into the key register.
  - round <= 1; go to ROUND.
  - in_valid with in_ready=0 is ignored; the source must hold it.
- ROUND, one round per edge:
  - Rounds 1..NR-1: SubBytes, ShiftRows, MixColumns, then AddRoundKey(K[round]).
  - Round NR: SubBytes, ShiftRows, then AddRoundKey(K[NR]) with no MixColumns.
  - K[r] is the FIPS-197 key expansion words w[4r..4r+3]:
    - For KEY_BITS=256, K[1] is init_key[127:0].
    - Expansion applies RotWord+SubWord+Rcon every 8 words and SubWord only at word index mod 8 == 4.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. The index is a 4-bit count and never wraps.
  - On the edge completing round NR: o_block <= result; go to HOLD.
  - Latency: o_valid is high after edge E0+NR (10 clocks for 128-bit keys, 14 for 256-bit keys).
- HOLD:
  - o_block and o_valid stay stable until an edge with o_ready=1, then state goes to IDLE and o_valid falls.
  - o_block retains its last value after the handshake; it is not cleared.
  - Earliest next accept is the cycle after the output handshake, so throughput is one block per NR+2 clocks with o_ready held high.
- Input changes on i_block, init_key or in_valid during ROUND or HOLD have no effect.
- o_ready high in IDLE or ROUND has no effect.
- All arithmetic is GF(2^8) with polynomial 0x11b. xtime(a) = {a[6:0],0} ^ (0x1b & {8{a[7]}}).

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, o_ready=1 -> o_block 3925841d02dc09fbdc118597196a0b32; o_valid rises exactly 10 clocks after the accept edge and stays high one cycle.
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- KEY_BITS=256, key 000102…1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 clocks.
- Backpressure:
  - Hold o_ready=0 for 20 cycles after o_valid -> o_block stable, in_ready=0, busy=1.
  - Second in_valid is not accepted until one cycle after the o_ready handshake; the second block's result is correct.
- Reset mid-flight: assert reset at round 5 -> outputs 0 immediately.
  - After release, a new block yields the correct ciphertext with no stale output.
- Input perturbation: toggle i_block and init_key randomly during ROUND -> result equals the vector captured at accept.
  - Back-to-back run of 100 random vectors against a reference model: zero mismatches.
